regfile_wb_arbiter: RTL

Shares the single register-file write port (RW/BusW/RegWr) between two writeback requesters: requester 0 (ALU/execute result) and requester 1 (load/multi-cycle unit, which may issue locked bursts). Each requester presents a valid/ready handshake. The arbiter registers the winning request on the rising edge of Clk, so RW/BusW/RegWr are stable before the register file samples them on the falling edge of the same cycle. It sits between the execute/memory stages and the register file in the single-cycle/multi-cycle datapath.

---
 rtl/regfile_wb_arbiter_pkg.sv | 11 +
 rtl/regfile_wb_arbiter_if.sv | 28 ++
 rtl/regfile_wb_arbiter_grant.sv | 22 ++
 rtl/regfile_wb_arbiter.sv | 93 +++++++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package regfile_wb_arbiter_pkg;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_e;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Two writeback requesters plus the registered register-file write port.
interface regfile_wb_arbiter_if;
  import regfile_wb_arbiter_pkg::*;

  logic                  Req0Valid;
  logic [REG_ADDR_W-1:0] Req0Addr;
  logic [REG_DATA_W-1:0] Req0Data;
  logic                  Req0Ready;
  logic                  Req1Valid;
  logic [REG_ADDR_W-1:0] Req1Addr;
  logic [REG_DATA_W-1:0] Req1Data;
  logic                  Req1Last;
  logic                  Req1Ready;
  logic [REG_ADDR_W-1:0] RW;
  logic [REG_DATA_W-1:0] BusW;
  logic                  RegWr;
  logic                  Locked;

  modport master (
    output Req0Valid, Req0Addr, Req0Data, Req1Valid, Req1Addr, Req1Data, Req1Last,
    input  Req0Ready, Req1Ready, RW, BusW, RegWr, Locked
  );

  modport slave (
    input  Req0Valid, Req0Addr, Req0Data, Req1Valid, Req1Addr, Req1Data, Req1Last,
    output Req0Ready, Req1Ready, RW, BusW, RegWr, Locked
  );
endinterface

// File: rtl/regfile_wb_arbiter_grant.sv
// Combinational grant select; ptr=0 favours requester 0 on a conflict.
module wbarb_grant
  import regfile_wb_arbiter_pkg::*;
(
  input  logic       v0,
  input  logic       v1,
  input  arb_state_e state,
  input  logic       ptr,
  output logic       gnt0,
  output logic       gnt1
);
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state == ST_LOCK) begin
      gnt1 = v1;
    end else begin
      gnt0 = v0 & (~v1 | ~ptr);
      gnt1 = v1 & (~v0 |  ptr);
    end
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: two requesters share the register-file write port.
// WBARB_ROUND_ROBIN_EN selects round-robin conflict resolution (default: requester 0 wins).
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
(
  input  logic                 Clk,
  input  logic                 Reset,
  regfile_wb_arbiter_if.slave  bus
);
  arb_state_e            state_q, state_d;
  logic [REG_ADDR_W-1:0] rw_q, rw_d;
  logic [REG_DATA_W-1:0] busw_q, busw_d;
  logic                  regwr_q, regwr_d;
  logic                  gnt0, gnt1, xfer0, xfer1;
  logic                  ptr;

`ifdef WBARB_ROUND_ROBIN_EN
  logic ptr_q, ptr_d;
  assign ptr = ptr_q;
`else
  assign ptr = 1'b0;
`endif

  wbarb_grant u_grant (
    .v0    (bus.Req0Valid),
    .v1    (bus.Req1Valid),
    .state (state_q),
    .ptr   (ptr),
    .gnt0  (gnt0),
    .gnt1  (gnt1)
  );

  assign bus.Req0Ready = gnt0 & ~Reset;
  assign bus.Req1Ready = gnt1 & ~Reset;
  assign xfer0 = bus.Req0Valid & bus.Req0Ready;
  assign xfer1 = bus.Req1Valid & bus.Req1Ready;

  always_comb begin
    state_d = state_q;
    rw_d    = rw_q;
    busw_d  = busw_q;
    regwr_d = 1'b0;
`ifdef WBARB_ROUND_ROBIN_EN
    ptr_d   = ptr_q;
`endif
    // Register-0 writes complete the handshake but leave the port untouched.
    if (xfer0) begin
      if (bus.Req0Addr != ZERO_REG) begin
        rw_d    = bus.Req0Addr;
        busw_d  = bus.Req0Data;
        regwr_d = 1'b1;
      end
`ifdef WBARB_ROUND_ROBIN_EN
      ptr_d = 1'b1;
`endif
    end else if (xfer1) begin
      if (bus.Req1Addr != ZERO_REG) begin
        rw_d    = bus.Req1Addr;
        busw_d  = bus.Req1Data;
        regwr_d = 1'b1;
      end
      state_d = bus.Req1Last ? ST_ARB : ST_LOCK;
`ifdef WBARB_ROUND_ROBIN_EN
      ptr_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_ARB;
      rw_q    <= '0;
      busw_q  <= '0;
      regwr_q <= 1'b0;
`ifdef WBARB_ROUND_ROBIN_EN
      ptr_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rw_q    <= rw_d;
      busw_q  <= busw_d;
      regwr_q <= regwr_d;
`ifdef WBARB_ROUND_ROBIN_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign bus.RW     = rw_q;
  assign bus.BusW   = busw_q;
  assign bus.RegWr  = regwr_q;
  assign bus.Locked = (state_q == ST_LOCK);
endmodule
